// File: rtl/demux1t2_8b_stream_if.sv
// Handshake bundle for the 1-to-2 byte demux: one input stream (D/Sel)
// and two output streams (A, B). The slave modport is the demux side.
interface demux1t2_8b_stream_if #(
    parameter int W = 8
) ();
    logic [W-1:0] D;
    logic         Sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] FA;
    logic [W-1:0] FB;
    logic         a_valid;
    logic         b_valid;
    logic         a_ready;
    logic         b_ready;

    modport slave (
        input  D, Sel, in_valid, a_ready, b_ready,
        output in_ready, FA, FB, a_valid, b_valid
    );

    modport master (
        output D, Sel, in_valid, a_ready, b_ready,
        input  in_ready, FA, FB, a_valid, b_valid
    );
endinterface

// File: rtl/demux1t2_8b_stream.sv
// Registered 1-to-2 byte demultiplexer. Each accepted byte is steered by Sel
// into a one-entry holding register for channel A (Sel=0) or B (Sel=1).
// A full channel that is being drained on the same edge accepts a new byte,
// so either channel sustains one byte per cycle.
// Optional macro DEMUX_COUNT_EN adds 8-bit wrapping per-channel consume
// counters cnt_a / cnt_b.

// One output channel: EMPTY/FULL holding register with its own handshake.
module demux1t2_8b_stream_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,   // accepted input byte targets this channel
    input  logic [W-1:0] d_i,
    input  logic         ready_i,  // downstream x_ready
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         free_o    // channel can take a byte this cycle
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]   cnt_o
`endif
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q;
    logic [W-1:0] data_q;

    // A full channel being drained this edge frees its slot for a new byte.
    assign free_o  = (state_q == EMPTY) || ready_i;
    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;

    // Channel FSM; data is only written on load so it is held while EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load_i) begin
                        state_q <= FULL;
                        data_q  <= d_i;
                    end
                end
                FULL: begin
                    // load implies ready_i here, so this is consume+reload
                    if (load_i) begin
                        data_q <= d_i;
                    end else if (ready_i) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign cnt_d = cnt_q + 8'd1;
    assign cnt_o = cnt_q;

    // Count bytes handed downstream; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == FULL) && ready_i) begin
            cnt_q <= cnt_d;
        end
    end
`endif
endmodule

module demux1t2_8b_stream #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1t2_8b_stream_if.slave  bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]           cnt_a,
    output logic [7:0]           cnt_b
`endif
);
    logic free_a;
    logic free_b;
    logic accept;
    logic load_a;
    logic load_b;

    // Ready depends only on the selected channel, never on in_valid, so a
    // stall on one channel never blocks the other.
    assign bus.in_ready = bus.Sel ? free_b : free_a;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_a       = accept && !bus.Sel;
    assign load_b       = accept &&  bus.Sel;

    demux1t2_8b_stream_chan #(.W(W)) u_chan_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_a),
        .d_i     (bus.D),
        .ready_i (bus.a_ready),
        .valid_o (bus.a_valid),
        .data_o  (bus.FA),
        .free_o  (free_a)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt_o   (cnt_a)
`endif
    );

    demux1t2_8b_stream_chan #(.W(W)) u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_b),
        .d_i     (bus.D),
        .ready_i (bus.b_ready),
        .valid_o (bus.b_valid),
        .data_o  (bus.FB),
        .free_o  (free_b)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt_o   (cnt_b)
`endif
    );
endmodule

// File: tb/tb_demux1t2_8b_stream.sv
// Randomized + directed bench for demux1t2_8b_stream. The reference keeps a
// FIFO of accepted-but-undelivered bytes per channel and derives every
// expected output from it.
module tb_demux1t2_8b_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux1t2_8b_stream_if #(.W(8)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
`endif

    demux1t2_8b_stream #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] last_a, last_b;
    int         cons_a, cons_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        cons_a = 0;
        cons_b = 0;
    endtask

    // One cycle: drive after negedge, check against model, update at posedge.
    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic ar, input logic br, output logic acc);
        logic exp_rdy, ca, cb;
        @(negedge clk);
        bus.in_valid = v;
        bus.Sel      = s;
        bus.D        = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        #1;
        chk("a_valid", bus.a_valid, qa.size() != 0);
        chk("b_valid", bus.b_valid, qb.size() != 0);
        chk("FA", bus.FA, last_a);
        chk("FB", bus.FB, last_b);
        exp_rdy = s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
        chk("in_ready", bus.in_ready, exp_rdy);
`ifdef DEMUX_COUNT_EN
        chk("cnt_a", cnt_a, 8'(cons_a));
        chk("cnt_b", cnt_b, 8'(cons_b));
`endif
        ca  = (qa.size() != 0) && ar;
        cb  = (qb.size() != 0) && br;
        acc = v && exp_rdy;
        if (ca) chk("a_order", bus.FA, qa[0]);
        if (cb) chk("b_order", bus.FB, qb[0]);
        @(posedge clk);
        if (ca) begin void'(qa.pop_front()); cons_a++; end
        if (cb) begin void'(qb.pop_front()); cons_b++; end
        if (acc) begin
            if (s) begin qb.push_back(d); last_b = d; end
            else   begin qa.push_back(d); last_a = d; end
        end
    endtask

    // Asynchronous reset pulse taken mid-cycle, checked before any edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_a_valid"}, bus.a_valid, 1'b0);
        chk({tag, "_b_valid"}, bus.b_valid, 1'b0);
        chk({tag, "_FA"}, bus.FA, 8'h00);
        chk({tag, "_FB"}, bus.FB, 8'h00);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
`ifdef DEMUX_COUNT_EN
        chk({tag, "_cnt_a"}, cnt_a, 8'h00);
        chk({tag, "_cnt_b"}, cnt_b, 8'h00);
`endif
        model_clear();
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       acc;
        logic       pv, ps, hold;
        logic [7:0] pd;
        logic       ar, br;

        bus.in_valid = 1'b0;
        bus.Sel      = 1'b0;
        bus.D        = 8'h00;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        model_clear();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_a_valid", bus.a_valid, 1'b0);
        chk("por_FA", bus.FA, 8'h00);
        chk("por_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic steer
        step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, acc);
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, acc);
        #1;
        chk("steer_FB", bus.FB, 8'h3C);
        chk("steer_b_valid", bus.b_valid, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Backpressure on A
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1, acc);
        chk("bp_stall", acc, 1'b0);
        chk("bp_hold_FA", bus.FA, 8'h11);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1, acc);
        chk("bp_pass", acc, 1'b1);
        #1;
        chk("bp_FA", bus.FA, 8'h22);
        chk("bp_a_valid", bus.a_valid, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Cross-channel independence: A stalled full, B streams
        step(1'b1, 1'b0, 8'h55, 1'b0, 1'b1, acc);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, acc);
            chk("cross_acc", acc, 1'b1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);
        #1;
        chk("cross_FA", bus.FA, 8'h55);
        chk("cross_a_valid", bus.a_valid, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Back-to-back streaming to A
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b1, acc);
            chk("stream_acc", acc, 1'b1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Reset mid-run with both channels full
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 8'h88, 1'b0, 1'b0, acc);
        do_reset("rst");

        // Random traffic; D/Sel held while stalled
        hold = 1'b0;
        pv = 1'b0; ps = 1'b0; pd = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 1'($urandom_range(0, 1));
                pd = 8'($urandom);
            end
            ar = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 2) != 0);
            step(pv, ps, pd, ar, br, acc);
            hold = pv && !acc;
        end

`ifdef DEMUX_COUNT_EN
        // Counter wrap: 257 consumes on B
        do_reset("rst2");
        for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        #1;
        chk("wrap_cnt_b", cnt_b, 8'd1);
        chk("wrap_cnt_a", cnt_a, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
